// File: rtl/posit_demapper_pkg.sv
// Shared types and constants for the posit demapper.
package posit_demapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SLEW    = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  localparam int unsigned N_POS = 10;

  localparam logic signed [15:0] POS_MIN = -16'sd90;
  localparam logic signed [15:0] POS_MAX =  16'sd90;

  // Centre value of each board position: -90 + 20*k.
  localparam logic signed [15:0] CENTRE [N_POS] = '{
    -16'sd90, -16'sd70, -16'sd50, -16'sd30, -16'sd10,
     16'sd10,  16'sd30,  16'sd50,  16'sd70,  16'sd90
  };

endpackage

// File: rtl/posit_onehot_enc.sv
// One-hot board vector to index plus validity flag.
module posit_onehot_enc
  import posit_demapper_pkg::*;
(
  input  logic [9:0] vec,
  output logic [3:0] idx,
  output logic       is_one_hot
);

  logic [3:0] cnt;

  always_comb begin
    cnt = '0;
    idx = '0;
    for (int unsigned i = 0; i < N_POS; i++) begin
      if (vec[i]) begin
        cnt = cnt + 4'd1;
        idx = 4'(i);
      end
    end
    is_one_hot = (cnt == 4'd1);
  end

endmodule

// File: rtl/posit_demapper.sv
// Board position to slew-limited signed tilt value.
module posit_demapper
  import posit_demapper_pkg::*;
#(
  parameter logic [15:0] STEP = 16'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        posit_valid,
  input  logic [9:0]  board_posit,
  output logic        posit_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_value,
  output logic        one_hot_err,
  output logic        busy
);

  localparam logic signed [15:0] STEP_S  = signed'(STEP);
  localparam logic signed [16:0] STEP_17 = signed'({1'b0, STEP});

  state_e            state_q, state_d;
  logic signed [15:0] out_q, out_d;
  logic signed [15:0] tgt_q, tgt_d;
  logic              err_q, err_d;

  logic [3:0]         enc_idx;
  logic               enc_one_hot;
  logic signed [16:0] diff;
  logic signed [16:0] mag;

  posit_onehot_enc u_enc (
    .vec        (board_posit),
    .idx        (enc_idx),
    .is_one_hot (enc_one_hot)
  );

  always_comb begin
    diff = 17'(tgt_q) - 17'(out_q);
    mag  = (diff < 0) ? -diff : diff;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tgt_d   = tgt_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (posit_valid) begin
          if (enc_one_hot) begin
            tgt_d   = CENTRE[enc_idx];
            state_d = ST_SLEW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SLEW: begin
        if (mag > STEP_17) begin
          out_d = (diff < 0) ? (out_q - STEP_S) : (out_q + STEP_S);
        end else begin
          out_d   = tgt_q;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end

  assign posit_ready = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_PRESENT);
  assign busy        = (state_q == ST_SLEW);
  assign out_value   = out_q;
  assign one_hot_err = err_q;

endmodule

// File: tb/tb_posit_demapper.sv
module tb_posit_demapper;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        posit_valid = 1'b0;
  logic [9:0]  board_posit = '0;
  logic        out_ready = 1'b0;
  logic        posit_ready;
  logic        out_valid;
  logic [15:0] out_value;
  logic        one_hot_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int model_pos = 0;

  posit_demapper #(.STEP(16'(STEP))) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .posit_valid (posit_valid),
    .board_posit (board_posit),
    .posit_ready (posit_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .one_hot_err (one_hot_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int val();
    return int'($signed(out_value));
  endfunction

  function automatic int abs_i(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept position k, follow the slew, hold PRESENT for 'hold' cycles, then handshake.
  // noise: -1 = posit_valid low while busy, 0..9 = that position offered, 10 = random vector.
  task automatic run_offer(input int k, input int hold, input int noise);
    int from, tgt, d, sgn, n, expv;
    from = model_pos;
    tgt  = 20 * k - 90;
    d    = abs_i(tgt - from);
    sgn  = (tgt >= from) ? 1 : -1;
    n    = (d + STEP - 1) / STEP;
    if (n == 0) n = 1;

    posit_valid = 1'b1;
    board_posit = 10'b1 << k;
    tick();
    check("accept_busy", int'(busy), 1);
    check("accept_ready", int'(posit_ready), 0);
    check("accept_value", val(), from);

    if (noise < 0) begin
      posit_valid = 1'b0;
    end else if (noise < 10) begin
      posit_valid = 1'b1;
      board_posit = 10'b1 << noise;
    end else begin
      posit_valid = 1'b1;
      board_posit = 10'($urandom);
    end

    for (int i = 1; i <= n; i++) begin
      tick();
      expv = from + sgn * ((i * STEP < d) ? i * STEP : d);
      check("slew_value", val(), expv);
      check("slew_out_valid", int'(out_valid), (i == n) ? 1 : 0);
      check("slew_busy", int'(busy), (i == n) ? 0 : 1);
      check("slew_err", int'(one_hot_err), 0);
    end

    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", int'(out_valid), 1);
      check("hold_value", val(), tgt);
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_ready", int'(posit_ready), 1);
    check("hs_out_valid", int'(out_valid), 0);
    check("hs_busy", int'(busy), 0);
    check("hs_value", val(), tgt);
    model_pos = tgt;
    if (noise != 10 && noise >= 0) begin
      // held position stays offered; the next run_offer consumes it on its first edge
    end else begin
      posit_valid = 1'b0;
    end
  endtask

  task automatic bad_offer(input logic [9:0] v);
    posit_valid = 1'b1;
    board_posit = v;
    tick();
    check("bad_err", int'(one_hot_err), 1);
    check("bad_ready", int'(posit_ready), 1);
    check("bad_busy", int'(busy), 0);
    check("bad_value", val(), model_pos);
    posit_valid = 1'b0;
    tick();
    check("bad_err_clear", int'(one_hot_err), 0);
    check("bad_value2", val(), model_pos);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_valid;
    logic [9:0] rv;

    #1;
    check("rst_ready", int'(posit_ready), 1);
    check("rst_value", val(), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_err", int'(one_hot_err), 0);
    #11 rst_n = 1'b1;
    tick();

    run_offer(5, 0, -1);                 // 0 -> +10 in 3 edges
    run_offer(0, 10, -1);                // +10 -> -90, 25 edges, held 10 cycles
    bad_offer(10'b00_0000_0000);
    bad_offer(10'b00_0001_1000);
    run_offer(5, 0, -1);                 // back to +10
    run_offer(5, 0, -1);                 // same position: one SLEW edge
    run_offer(9, 2, 3);                  // bit3 offered throughout SLEW/PRESENT
    run_offer(3, 0, -1);                 // accepted on the edge after the handshake

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(3) == 0) begin
        rv = 10'($urandom);
        if ($countones(rv) == 1) rv = '0;
        bad_offer(rv);
      end
      if ($urandom_range(1) == 0)
        run_offer(int'($urandom_range(9)), int'($urandom_range(3)), 10);
      else
        run_offer(int'($urandom_range(9)), int'($urandom_range(3)), -1);
    end

    // abort mid-SLEW with an asynchronous reset between edges
    run_offer(0, 0, -1);
    posit_valid = 1'b1;
    board_posit = 10'b10_0000_0000;
    tick();
    posit_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_value", val(), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(posit_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    #10 rst_n = 1'b1;
    model_pos = 0;
    seen_valid = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    check("abort_no_valid", seen_valid, 0);
    check("abort_idle_value", val(), 0);
    run_offer(2, 1, -1);                 // slews from 0 to -50

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
